// File: rtl/n_bit_alu_pipe.sv
// n_bit_alu_pipe: pipelined add/subtract unit with accumulator, status flags and
// a valid/ready handshake. The op is evaluated at input accept; the result and
// flags then travel through STAGES registers and appear at the output, in order.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operand/op present this cycle
//   in_ready   block accepts input this cycle (combinational)
//   a, b       operands, WIDTH bits
//   op         00 ADD, 01 SUBMAG, 10 SUB2C, 11 ACC
//   out_valid  result/flags valid
//   out_ready  consumer takes the result this cycle
//   result     WIDTH-bit result
//   sgn        sign flag (a<b for SUBMAG, otherwise result msb)
//   carry      carry out (ADD/ACC) or borrow (SUB2C)
//   zero       result == 0
//   ovf        signed overflow (ADD/SUB2C only)
module n_bit_alu_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             sgn,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OpAdd    = 2'b00,
        OpSubMag = 2'b01,
        OpSub2c  = 2'b10,
        OpAcc    = 2'b11
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             sgn;
        logic             carry;
        logic             zero;
        logic             ovf;
    } res_t;

    logic             advance;
    logic             accept;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   sum_acc;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    res_t             calc;

    logic [STAGES-1:0] vld_q;
    res_t              pipe_q [STAGES];

    // The whole pipe moves as one; it only freezes when the output is held.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    always_comb begin
        // Extra msb of each sum/difference carries the carry or borrow.
        sum_add = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        sum_acc = {1'b0, acc_q} + {1'b0, a};
        calc    = '0;
        unique case (op_e'(op))
            OpAdd: begin
                calc.r     = sum_add[WIDTH-1:0];
                calc.carry = sum_add[WIDTH];
                calc.sgn   = sum_add[WIDTH-1];
                calc.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OpSubMag: begin
                // Borrow out of a-b means a<b, so take b-a for the magnitude.
                calc.r   = diff[WIDTH] ? (b - a) : diff[WIDTH-1:0];
                calc.sgn = diff[WIDTH];
            end
            OpSub2c: begin
                calc.r     = diff[WIDTH-1:0];
                calc.carry = diff[WIDTH];
                calc.sgn   = diff[WIDTH-1];
                calc.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpAcc: begin
                calc.r     = sum_acc[WIDTH-1:0];
                calc.carry = sum_acc[WIDTH];
                calc.sgn   = sum_acc[WIDTH-1];
            end
        endcase
        calc.zero = (calc.r == '0);
    end

    // Accumulator commits at accept, so back-to-back ACC ops chain directly.
    assign acc_d = (accept && (op_e'(op) == OpAcc)) ? sum_acc[WIDTH-1:0] : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            if (advance) begin
                vld_q[0]  <= accept;
                pipe_q[0] <= accept ? calc : '0;
                for (int i = 1; i < int'(STAGES); i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = pipe_q[STAGES-1].r;
    assign sgn       = pipe_q[STAGES-1].sgn;
    assign carry     = pipe_q[STAGES-1].carry;
    assign zero      = pipe_q[STAGES-1].zero;
    assign ovf       = pipe_q[STAGES-1].ovf;

endmodule

// File: tb/tb_n_bit_alu_pipe.sv
// tb_n_bit_alu_pipe: bench for n_bit_alu_pipe at WIDTH=4 with three instances:
// index 0 at STAGES=2 (directed tests), 1 at STAGES=1 and 2 at STAGES=4
// (exhaustive sweep). Expected outputs are queued on accept and compared in
// order as each instance's outputs are taken.
module tb_n_bit_alu_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [1:0]   op        [3];
    logic [W-1:0] a         [3];
    logic [W-1:0] b         [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [W-1:0] result    [3];
    logic         sgn       [3];
    logic         carry     [3];
    logic         zero      [3];
    logic         ovf       [3];

    logic [7:0] sb [3][$];
    int         mdl_acc [3];
    bit         rnd_run [3];
    int         n_pass   = 0;
    int         n_checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pk(input int r, input bit s, input bit c, input bit z,
                                      input bit v);
        logic [3:0] r4;
        r4 = r[3:0];
        return {r4, s, c, z, v};
    endfunction

    // Integer reference model; returns {r, sgn, carry, zero, ovf}.
    function automatic logic [7:0] model(input int o, input int av, input int bv,
                                         inout int acc);
        int s;
        int r;
        bit c;
        bit sg;
        bit v;
        s = 0; r = 0; c = 0; sg = 0; v = 0;
        case (o)
            0: begin
                s = av + bv; r = s % 16; c = (s >= 16); sg = (r >= 8);
                v = ((av >= 8) == (bv >= 8)) && ((r >= 8) != (av >= 8));
            end
            1: begin
                r = (av >= bv) ? av - bv : bv - av; sg = (av < bv);
            end
            2: begin
                r = (av - bv + 16) % 16; c = (av < bv); sg = (r >= 8);
                v = ((av >= 8) != (bv >= 8)) && ((r >= 8) != (av >= 8));
            end
            default: begin
                s = acc + av; r = s % 16; c = (s >= 16); sg = (r >= 8); acc = r;
            end
        endcase
        return pk(r, sg, c, (r == 0), v);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        n_bit_alu_pipe #(
            .WIDTH (W),
            .STAGES(k == 0 ? 2 : (k == 1 ? 1 : 4))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[k]),
            .in_ready (in_ready[k]),
            .a        (a[k]),
            .b        (b[k]),
            .op       (op[k]),
            .out_valid(out_valid[k]),
            .out_ready(out_ready[k]),
            .result   (result[k]),
            .sgn      (sgn[k]),
            .carry    (carry[k]),
            .zero     (zero[k]),
            .ovf      (ovf[k])
        );

        // Output side of the scoreboard: a transfer happens at the next edge.
        always @(negedge clk) begin
            if (!rst && out_valid[k] && out_ready[k]) begin
                if (sb[k].size() == 0) begin
                    chk($sformatf("unexpected_out_k%0d", k), 16'd1, 16'd0);
                end else begin
                    chk($sformatf("out_k%0d", k),
                        {8'h0, result[k], sgn[k], carry[k], zero[k], ovf[k]},
                        {8'h0, sb[k].pop_front()});
                end
            end
        end
    end

    // Present one op; queue its expectation when it is seen accepted.
    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input int k, input logic [1:0] o, input int av, input int bv,
                        input logic [7:0] exp);
        int t = 0;
        in_valid[k] = 1'b1;
        op[k]       = o;
        a[k]        = av[W-1:0];
        b[k]        = bv[W-1:0];
        @(negedge clk);
        while (!in_ready[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (in_ready[k]) sb[k].push_back(exp);
        else chk($sformatf("send_timeout_k%0d", k), 16'd0, 16'd1);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int t = 0;
        while (sb[k].size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk($sformatf("drain_k%0d", k), 16'(sb[k].size()), 16'd0);
    endtask

    task automatic exhaustive(input int k);
        logic [7:0] e;
        rnd_run[k] = 1'b1;
        fork
            begin
                for (int o = 0; o < 4; o++) begin
                    for (int bv = 0; bv < 16; bv++) begin
                        for (int av = 0; av < 16; av++) begin
                            if ($urandom_range(0, 3) == 0) begin
                                @(posedge clk);
                                #1;
                            end
                            e = model(o, av, bv, mdl_acc[k]);
                            send(k, o[1:0], av, bv, e);
                        end
                    end
                end
                rnd_run[k] = 1'b0;
            end
            begin
                while (rnd_run[k]) begin
                    @(posedge clk);
                    #1;
                    out_ready[k] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready[k] = 1'b1;
        drain(k);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            op[k]        = 2'b00;
            a[k]         = '0;
            b[k]         = '0;
            mdl_acc[k]   = 0;
            rnd_run[k]   = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_state_k%0d", k),
                {7'h0, out_valid[k], result[k], sgn[k], carry[k], zero[k], ovf[k]}, 16'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SUBMAG, ADD, SUB2C directed values
        send(0, 2'b01, 3, 5, pk(2, 1, 0, 0, 0));
        send(0, 2'b01, 5, 3, pk(2, 0, 0, 0, 0));
        send(0, 2'b01, 9, 9, pk(0, 0, 0, 1, 0));
        send(0, 2'b00, 15, 1, pk(0, 0, 1, 1, 0));
        send(0, 2'b00, 7, 1, pk(8, 1, 0, 0, 1));
        send(0, 2'b10, 3, 5, pk(14, 1, 1, 0, 0));
        send(0, 2'b10, 8, 1, pk(7, 0, 0, 0, 1));
        drain(0);

        // Reset with two ops in flight, one of them loading acc
        send(0, 2'b11, 1, 0, pk(1, 0, 0, 0, 0));
        send(0, 2'b00, 3, 4, pk(7, 0, 0, 0, 0));
        chk("inflight_valid", {15'h0, out_valid[0]}, 16'h1);
        rst = 1'b1;
        sb[0].delete();
        #1;
        chk("rst_async", {7'h0, out_valid[0], result[0], sgn[0], carry[0], zero[0], ovf[0]},
            16'h0);
        // An op offered while in reset must be dropped.
        in_valid[0] = 1'b1;
        op[0]       = 2'b00;
        a[0]        = 4'd5;
        b[0]        = 4'd5;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 2'b11, 9, 3, pk(9, 1, 0, 0, 0));
        send(0, 2'b11, 9, 7, pk(2, 0, 1, 0, 0));
        drain(0);

        // Backpressure: first output is held for 5 cycles
        out_ready[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, 2'b00, i, 1, pk(i + 1, 0, 0, 0, 0));
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!out_valid[0] && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_first_valid", {15'h0, out_valid[0]}, 16'h1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", {15'h0, in_ready[0]}, 16'h0);
                    chk("bp_hold", {7'h0, out_valid[0], result[0], sgn[0], carry[0], zero[0],
                        ovf[0]}, {7'h0, 1'b1, pk(1, 0, 0, 0, 0)});
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        drain(0);

        // Exhaustive sweep at STAGES=1 and STAGES=4
        rst = 1'b1;
        for (int k = 0; k < 3; k++) mdl_acc[k] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            exhaustive(1);
            exhaustive(2);
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
